// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module hazard_ctrl #(
    parameter int DWAIT_MAX = 64,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_dRENi,
    input  logic [4:0]       ex_rt,
    input  logic             ex_taken,
    input  logic             mem_dREQ,
    input  logic             mem_halt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(DWAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(DWAIT_MAX);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        HALTING = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [WC_W-1:0] wcnt, wcnt_n;
    logic            mem_err_n;
    logic            load_use;
    logic            dstall;

    assign load_use = ex_dRENi && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        state_n     = state;
        wcnt_n      = '0;
        mem_err_n   = mem_err;
        dstall      = 1'b0;

        case (state)
            HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            DWAIT: begin
                if (!dhit) begin
                    dstall = 1'b1;
                    wcnt_n = (wcnt == WC_MAX) ? wcnt : wcnt + 1'b1;
                    if (wcnt_n == WC_MAX)
                        mem_err_n = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            HALTING: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                if (wb_halt)
                    state_n = HALTED;
            end
            default: begin
                if (mem_dREQ && !dhit) begin
                    dstall  = 1'b1;
                    state_n = DWAIT;
                end else begin
                    if (mem_halt)
                        state_n = HALTING;
                    // a taken branch squashes the ID instruction, so load-use is moot
                    if (ex_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            end
        endcase

        // the memory stage holds; WB receives a bubble each waiting cycle
        if (dstall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
        end

        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            mem_err <= mem_err_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_count <= '0;
        else if (!pc_en && (state != HALTED) && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

    assign halt = (state == HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a reference model
module tb_hazard_ctrl;

    localparam int DMAX = 4;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    localparam logic [8:0] V_DEF     = 9'b110101010;
    localparam logic [8:0] V_DW      = 9'b000000011;
    localparam logic [8:0] V_HALTING = 9'b000111110;
    localparam logic [8:0] V_TAKEN   = 9'b111111010;
    localparam logic [8:0] V_LU      = 9'b000111010;
    localparam logic [8:0] V_IMISS   = 9'b011101010;
    localparam logic [8:0] V_ZERO    = 9'b000000000;

    localparam int MR = 0, MD = 1, MHG = 2, MHD = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ihit, dhit, ex_dRENi, ex_taken, mem_dREQ, mem_halt, wb_halt;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, exmem_flush, memwb_en, memwb_flush, halt, mem_err;
    logic [CW-1:0] stall_count;
    logic [8:0]    outs;

    int n_pass  = 0;
    int n_total = 0;

    int   m_mode = MR;
    int   m_wcnt = 0;
    logic m_err  = 1'b0;
    int   m_scnt = 0;

    hazard_ctrl #(.DWAIT_MAX(DMAX), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .ex_dRENi(ex_dRENi), .ex_rt(ex_rt),
        .ex_taken(ex_taken), .mem_dREQ(mem_dREQ), .mem_halt(mem_halt), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halt(halt), .mem_err(mem_err), .stall_count(stall_count)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, memwb_flush};

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Expected enable/flush vector from the rule table, highest priority first.
    function automatic logic [8:0] model_out();
        logic lu;
        lu = ex_dRENi && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        if (RST)            return V_ZERO;
        if (m_mode == MHD)  return V_ZERO;
        if (m_mode == MD)   return dhit ? V_DEF : V_DW;
        if (m_mode == MHG)  return V_HALTING;
        if (mem_dREQ && !dhit) return V_DW;
        if (ex_taken)       return V_TAKEN;
        if (lu)             return V_LU;
        if (!ihit)          return V_IMISS;
        return V_DEF;
    endfunction

    function automatic logic model_pc();
        logic [8:0] o;
        o = model_out();
        return o[8];
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_mode <= MR;
            m_wcnt <= 0;
            m_err  <= 1'b0;
            m_scnt <= 0;
        end else begin
            if (m_mode != MHD && !model_pc() && m_scnt < SMAX)
                m_scnt <= m_scnt + 1;
            case (m_mode)
                MR: begin
                    if (mem_dREQ && !dhit) m_mode <= MD;
                    else if (mem_halt)     m_mode <= MHG;
                end
                MD: begin
                    if (dhit) begin
                        m_mode <= MR;
                        m_wcnt <= 0;
                    end else begin
                        m_wcnt <= (m_wcnt < DMAX) ? m_wcnt + 1 : m_wcnt;
                        if (m_wcnt + 1 >= DMAX) m_err <= 1'b1;
                    end
                end
                MHG: if (wb_halt) m_mode <= MHD;
                default: ;
            endcase
        end
    end

    always @(negedge CLK) begin
        chk("outs", 32'(outs), 32'(model_out()));
        chk("halt", 32'(halt), 32'(m_mode == MHD));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("stall_count", 32'(stall_count), 32'(m_scnt));
    end

    task automatic clear_in();
        ihit = 1'b1; dhit = 1'b0; ex_dRENi = 1'b0; ex_taken = 1'b0;
        mem_dREQ = 1'b0; mem_halt = 1'b0; wb_halt = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    endtask

    task automatic rst_pulse();
        clear_in();
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        clear_in();
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("rst_outs", 32'(outs), 32'(V_ZERO));
        chk("rst_cnt", 32'(stall_count), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_err", 32'(mem_err), 0);
        next_cyc();
        RST = 1'b0;

        ex_dRENi = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd7;
        @(negedge CLK); chk("lu_outs", 32'(outs), 32'(V_LU));
        next_cyc(); ex_dRENi = 1'b0;
        @(negedge CLK); chk("lu_once", 32'(outs), 32'(V_DEF));
        chk("lu_cnt", 32'(stall_count), 1);
        next_cyc(); ex_dRENi = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge CLK); chk("lu_r0", 32'(outs), 32'(V_DEF));
        next_cyc(); ex_rt = 5'd2; id_rs = 5'd2; ex_taken = 1'b1;
        @(negedge CLK); chk("taken_lu", 32'(outs), 32'(V_TAKEN));
        next_cyc(); clear_in();
        @(negedge CLK); chk("taken_cnt", 32'(stall_count), 1);

        next_cyc(); rst_pulse();
        mem_dREQ = 1'b1; dhit = 1'b0;
        repeat (3) begin
            @(negedge CLK); chk("dw_outs", 32'(outs), 32'(V_DW));
            next_cyc();
        end
        dhit = 1'b1;
        @(negedge CLK); chk("dw_end", 32'(outs), 32'(V_DEF));
        next_cyc(); mem_dREQ = 1'b0; dhit = 1'b0;
        @(negedge CLK); chk("dw_cnt", 32'(stall_count), 3);
        chk("dw_run", 32'(outs), 32'(V_DEF));

        next_cyc(); rst_pulse();
        mem_dREQ = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        repeat (4) @(negedge CLK);
        chk("wd_before", 32'(mem_err), 0);
        @(negedge CLK); chk("wd_rise", 32'(mem_err), 1);
        next_cyc(); dhit = 1'b1;
        @(negedge CLK);
        next_cyc(); mem_dREQ = 1'b0; dhit = 1'b0;
        @(negedge CLK); chk("wd_sticky", 32'(mem_err), 1);
        next_cyc(); rst_pulse();
        @(negedge CLK); chk("wd_clear", 32'(mem_err), 0);

        next_cyc(); rst_pulse();
        mem_halt = 1'b1;
        @(negedge CLK); chk("halt_run", 32'(outs), 32'(V_DEF));
        next_cyc(); mem_halt = 1'b0; wb_halt = 1'b1;
        @(negedge CLK); chk("halting", 32'(outs), 32'(V_HALTING));
        chk("halting_flag", 32'(halt), 0);
        next_cyc(); wb_halt = 1'b0;
        repeat (12) begin
            ihit = 1'($urandom); dhit = 1'($urandom); mem_dREQ = 1'($urandom);
            @(negedge CLK);
            chk("halted_outs", 32'(outs), 32'(V_ZERO));
            chk("halted_flag", 32'(halt), 1);
            next_cyc();
        end
        chk("halt_cnt", 32'(stall_count), 1);

        rst_pulse();
        mem_dREQ = 1'b1; dhit = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("arst_outs", 32'(outs), 32'(V_ZERO));
        chk("arst_cnt", 32'(stall_count), 0);
        next_cyc(); RST = 1'b0; mem_dREQ = 1'b0;
        @(negedge CLK); chk("arst_run", 32'(outs), 32'(V_DEF));
        chk("arst_cnt0", 32'(stall_count), 0);

        next_cyc(); rst_pulse();
        ihit = 1'b0;
        repeat (20) next_cyc();
        @(negedge CLK); chk("sat_outs", 32'(outs), 32'(V_IMISS));
        chk("sat_cnt", 32'(stall_count), SMAX);

        next_cyc(); rst_pulse();
        repeat (3000) begin
            ihit     = ($urandom_range(0, 99) < 80);
            dhit     = 1'($urandom);
            mem_dREQ = ($urandom_range(0, 99) < 30);
            ex_dRENi = ($urandom_range(0, 99) < 30);
            ex_taken = ($urandom_range(0, 99) < 10);
            mem_halt = ($urandom_range(0, 99) < 3);
            wb_halt  = ($urandom_range(0, 99) < 40);
            ex_rt    = 5'($urandom_range(0, 3));
            id_rs    = 5'($urandom_range(0, 3));
            id_rt    = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) begin
                #1 RST = 1'b1;
                #1 RST = 1'b0;
            end
            next_cyc();
        end

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
